char_motion_sequencer: RTL and testbench

Per-frame motion sequencer for the player character. It owns character X/Y position and a ground/rise/apex/fall jump state machine, driven by two USB HID keycodes.
- All logic runs on the system clock CLK. frame_clk is treated as data and edge-detected internally to produce a one-cycle frame tick.
- Sits between the keyboard keycode registers and the sprite/collision logic; it replaces ad-hoc motion logic with a single sequenced datapath.

---
 rtl/char_pkg.sv | 36 +++
 rtl/frame_tick_gen.sv | 29 ++
 rtl/char_motion_sequencer.sv | 130 +++++++++++++
 tb/tb_char_motion_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// Shared types and constants for the character motion sequencer.
package char_pkg;

   localparam int unsigned POS_W = 10;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_APEX   = 2'd2,
      ST_FALL   = 2'd3
   } state_e;

   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   localparam logic [POS_W-1:0] CHAR_SIZE = 10'd4;
   localparam logic [POS_W-1:0] X_START   = 10'd320;
   localparam logic [POS_W-1:0] Y_GROUND  = 10'd296;
   localparam logic [POS_W-1:0] X_MIN     = 10'd4;
   localparam logic [POS_W-1:0] X_MAX     = 10'd635;
   localparam logic [POS_W-1:0] Y_MIN     = 10'd4;
   localparam logic [POS_W-1:0] X_STEP    = 10'd1;
   localparam logic [POS_W-1:0] Y_STEP    = 10'd2;

   localparam int unsigned RISE_FRAMES = 16;
   localparam int unsigned APEX_FRAMES = 4;

   // A key counts as pressed if it appears in either keycode slot.
   function automatic logic key_hit(input logic [7:0] k0, input logic [7:0] k1,
                                    input logic [7:0] key);
      return (k0 == key) || (k1 == key);
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Turns an asynchronous-ish frame strobe into a one-CLK-cycle tick per rising edge.
module frame_tick_gen (
   input  logic CLK,
   input  logic Reset,
   input  logic frame_clk,
   output logic tick
);

   logic fc_q, fc_d;
   logic fc_prev_q, fc_prev_d;

   always_comb begin
      fc_d      = frame_clk;
      fc_prev_d = fc_q;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         fc_q      <= 1'b0;
         fc_prev_q <= 1'b0;
      end else begin
         fc_q      <= fc_d;
         fc_prev_q <= fc_prev_d;
      end
   end

   assign tick = fc_q & ~fc_prev_q;

endmodule

// File: rtl/char_motion_sequencer.sv
// Per-frame character position datapath and ground/rise/apex/fall jump sequencer.
module char_motion_sequencer
   import char_pkg::*;
(
   input  logic             CLK,
   input  logic             Reset,
   input  logic             frame_clk,
   input  logic [7:0]       keycode0,
   input  logic [7:0]       keycode1,
   output logic [POS_W-1:0] CharX,
   output logic [POS_W-1:0] CharY,
   output logic [POS_W-1:0] CharS,
   output logic             airborne,
   output logic [1:0]       HEXstate
);

   localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_FRAMES - 1);
   localparam logic [CNT_W-1:0] APEX_LAST = CNT_W'(APEX_FRAMES - 1);

   logic tick;
   logic key_left, key_right, key_jump;

   state_e           state_q, state_d;
   logic [POS_W-1:0] x_q, x_d;
   logic [POS_W-1:0] y_q, y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;

   logic [POS_W:0] x_dec, x_inc, y_up, y_dn;

   frame_tick_gen u_tick (
      .CLK       (CLK),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .tick      (tick)
   );

   assign key_left  = key_hit(keycode0, keycode1, KEY_A);
   assign key_right = key_hit(keycode0, keycode1, KEY_D);
   assign key_jump  = key_hit(keycode0, keycode1, KEY_SPACE);

   // Horizontal motion: one extra bit so underflow/overflow is visible before clamping.
   always_comb begin
      x_d   = x_q;
      x_dec = {1'b0, x_q} - {1'b0, X_STEP};
      x_inc = {1'b0, x_q} + {1'b0, X_STEP};
      if (tick) begin
         if (key_left && !key_right) begin
            if (x_dec[POS_W] || (x_dec < {1'b0, X_MIN})) x_d = X_MIN;
            else                                          x_d = x_dec[POS_W-1:0];
         end else if (key_right && !key_left) begin
            if (x_inc > {1'b0, X_MAX}) x_d = X_MAX;
            else                        x_d = x_inc[POS_W-1:0];
         end
      end
   end

   // Jump sequencer and vertical motion.
   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      y_up    = {1'b0, y_q} - {1'b0, Y_STEP};
      y_dn    = {1'b0, y_q} + {1'b0, Y_STEP};
      if (tick) begin
         if (!key_jump) armed_d = 1'b1;
         unique case (state_q)
            ST_GROUND: begin
               y_d = Y_GROUND;
               if (key_jump && armed_q) begin
                  state_d = ST_RISE;
                  cnt_d   = '0;
                  armed_d = 1'b0;
               end
            end
            ST_RISE: begin
               if (y_up[POS_W] || (y_up < {1'b0, Y_MIN})) y_d = Y_MIN;
               else                                        y_d = y_up[POS_W-1:0];
               if (cnt_q == RISE_LAST) begin
                  state_d = ST_APEX;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_APEX: begin
               if (cnt_q == APEX_LAST) begin
                  state_d = ST_FALL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_FALL: begin
               if (y_dn >= {1'b0, Y_GROUND}) begin
                  y_d     = Y_GROUND;
                  state_d = ST_GROUND;
               end else begin
                  y_d = y_dn[POS_W-1:0];
               end
            end
            default: state_d = ST_GROUND;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= ST_GROUND;
         x_q     <= X_START;
         y_q     <= Y_GROUND;
         cnt_q   <= '0;
         armed_q <= 1'b1;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   assign CharX    = x_q;
   assign CharY    = y_q;
   assign CharS    = CHAR_SIZE;
   assign HEXstate = state_q;
   assign airborne = (state_q != ST_GROUND);

endmodule

// File: tb/tb_char_motion_sequencer.sv
// Scoreboard bench: a behavioural model predicts each frame, DUT output is compared after the tick.
module tb_char_motion_sequencer;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk = 1'b0;
   logic [7:0] keycode0 = 8'h00;
   logic [7:0] keycode1 = 8'h00;
   logic [9:0] CharX, CharY, CharS;
   logic       airborne;
   logic [1:0] HEXstate;

   char_motion_sequencer dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .keycode0  (keycode0),
      .keycode1  (keycode1),
      .CharX     (CharX),
      .CharY     (CharY),
      .CharS     (CharS),
      .airborne  (airborne),
      .HEXstate  (HEXstate)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int x;
      int y;
      int st;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state
   int   mx, my, mst, mcnt;
   bit   marm;
   int   launches;
   logic [1:0] prev_hex;

   task automatic model_reset();
      mx = 320; my = 296; mst = 0; mcnt = 0; marm = 1'b1;
   endtask

   task automatic model_step(input bit l, input bit r, input bit j);
      if (l && !r) mx = (mx - 1 < 4) ? 4 : mx - 1;
      else if (r && !l) mx = (mx + 1 > 635) ? 635 : mx + 1;
      case (mst)
         0: begin
            my = 296;
            if (j && marm) begin mst = 1; mcnt = 0; marm = 1'b0; end
         end
         1: begin
            my = (my - 2 < 4) ? 4 : my - 2;
            if (mcnt == 15) begin mst = 2; mcnt = 0; end else mcnt++;
         end
         2: begin
            if (mcnt == 3) begin mst = 3; mcnt = 0; end else mcnt++;
         end
         default: begin
            my = my + 2;
            if (my >= 296) begin my = 296; mst = 0; end
         end
      endcase
      if (!j) marm = 1'b1;
   endtask

   // One frame: rising edge on frame_clk, compare two CLK edges later, then drop the strobe.
   task automatic frame(input logic [7:0] k0, input logic [7:0] k1);
      exp_t e;
      bit l, r, j;
      @(negedge CLK);
      keycode0 = k0; keycode1 = k1; frame_clk = 1'b1;
      l = (k0 == 8'h04) || (k1 == 8'h04);
      r = (k0 == 8'h07) || (k1 == 8'h07);
      j = (k0 == 8'h2C) || (k1 == 8'h2C);
      model_step(l, r, j);
      sb_q.push_back('{mx, my, mst});
      @(posedge CLK); @(posedge CLK); #1;
      e = sb_q.pop_front();
      checks++;
      if (CharX !== 10'(e.x)) begin errors++; $display("FAIL frame_x: CharX=%0d expected %0d", CharX, e.x); end
      checks++;
      if (CharY !== 10'(e.y)) begin errors++; $display("FAIL frame_y: CharY=%0d expected %0d", CharY, e.y); end
      checks++;
      if (HEXstate !== 2'(e.st)) begin errors++; $display("FAIL frame_state: HEXstate=%0d expected %0d", HEXstate, e.st); end
      checks++;
      if (airborne !== (e.st != 0)) begin errors++; $display("FAIL frame_airborne: airborne=%0b expected %0b", airborne, e.st != 0); end
      if (prev_hex == 2'd0 && HEXstate == 2'd1) launches++;
      prev_hex = HEXstate;
      @(negedge CLK);
      frame_clk = 1'b0;
      @(posedge CLK);
   endtask

   task automatic frames(input int n, input logic [7:0] k0, input logic [7:0] k1);
      for (int i = 0; i < n; i++) frame(k0, k1);
   endtask

   task automatic check_val(input string name, input logic [9:0] got, input logic [9:0] want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL %s: got %0d expected %0d", name, got, want); end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      model_reset();
      check_val("reset_x", CharX, 10'd320);
      check_val("reset_y", CharY, 10'd296);
      check_val("reset_s", CharS, 10'd4);
      check_val("reset_state", 10'(HEXstate), 10'd0);
      check_val("reset_airborne", 10'(airborne), 10'd0);
      @(negedge CLK); Reset = 1'b0;
      prev_hex = 2'd0;
      frames(3, 8'h00, 8'h00);
      check_val("idle_x", CharX, 10'd320);
      check_val("idle_y", CharY, 10'd296);
   endtask

   task automatic test_latency();
      int old_x;
      old_x = mx;
      @(negedge CLK);
      keycode0 = 8'h07; keycode1 = 8'h00; frame_clk = 1'b1;
      @(posedge CLK); #1;
      check_val("latency_before_tick", CharX, 10'(old_x));
      @(posedge CLK); #1;
      model_step(1'b0, 1'b1, 1'b0);
      check_val("latency_after_tick", CharX, 10'(mx));
      repeat (3) @(posedge CLK); #1;
      check_val("latency_single_tick", CharX, 10'(mx));
      @(negedge CLK); frame_clk = 1'b0; keycode0 = 8'h00;
      @(posedge CLK);
   endtask

   task automatic test_horizontal();
      frames(9, 8'h07, 8'h00);
      check_val("right_10", CharX, 10'd330);
      frames(5, 8'h04, 8'h07);
      check_val("left_right_hold", CharX, 10'd330);
      frames(3, 8'h00, 8'h04);
      check_val("left_slot1", CharX, 10'd327);
   endtask

   task automatic test_saturation();
      frames(400, 8'h07, 8'h00);
      check_val("sat_right", CharX, 10'd635);
      frames(700, 8'h04, 8'h00);
      check_val("sat_left", CharX, 10'd4);
   endtask

   task automatic test_jump();
      int l0;
      l0 = launches;
      frame(8'h2C, 8'h00);
      check_val("launch_state", 10'(HEXstate), 10'd1);
      frames(16, 8'h00, 8'h00);
      check_val("rise_top_y", CharY, 10'd264);
      check_val("apex_state", 10'(HEXstate), 10'd2);
      frames(4, 8'h00, 8'h00);
      check_val("apex_y", CharY, 10'd264);
      check_val("fall_state", 10'(HEXstate), 10'd3);
      frames(16, 8'h00, 8'h00);
      check_val("landed_y", CharY, 10'd296);
      check_val("landed_state", 10'(HEXstate), 10'd0);
      check_val("one_launch", 10'(launches - l0), 10'd1);
   endtask

   task automatic test_back_to_back();
      int l0;
      l0 = launches;
      frames(80, 8'h00, 8'h2C);
      check_val("held_one_jump", 10'(launches - l0), 10'd1);
      check_val("held_state", 10'(HEXstate), 10'd0);
      frame(8'h00, 8'h00);
      frame(8'h2C, 8'h00);
      check_val("rearm_launch", 10'(HEXstate), 10'd1);
      frames(36, 8'h00, 8'h00);
      check_val("rearm_landed", 10'(HEXstate), 10'd0);
   endtask

   task automatic test_reset_mid_jump();
      int guard;
      frame(8'h2C, 8'h07);
      guard = 0;
      while (!(mst == 3 && my == 280) && guard < 60) begin
         frame(8'h00, 8'h07);
         guard++;
      end
      check_val("reached_fall_280", CharY, 10'd280);
      @(negedge CLK);
      Reset = 1'b1; frame_clk = 1'b1; keycode0 = 8'h07;
      @(posedge CLK); #1;
      check_val("midreset_x", CharX, 10'd320);
      check_val("midreset_y", CharY, 10'd296);
      check_val("midreset_state", 10'(HEXstate), 10'd0);
      check_val("midreset_airborne", 10'(airborne), 10'd0);
      @(negedge CLK);
      Reset = 1'b0; frame_clk = 1'b0; keycode0 = 8'h00;
      repeat (4) @(posedge CLK); #1;
      check_val("post_reset_x", CharX, 10'd320);
      check_val("post_reset_y", CharY, 10'd296);
      model_reset();
      prev_hex = 2'd0;
      frames(2, 8'h2C, 8'h00);
      check_val("post_reset_jump", 10'(HEXstate), 10'd1);
   endtask

   initial begin
      launches = 0;
      prev_hex = 2'd0;
      model_reset();
      test_reset();
      test_latency();
      test_horizontal();
      test_saturation();
      test_jump();
      test_back_to_back();
      test_reset_mid_jump();
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left expected 0", sb_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
